// File: rtl/pix_op_pkg.sv
// ---------------------------------------------------------------------------
// pix_op_pkg
// Shared definitions for the pixel point-operation frame sequencer:
//   PIX_W / ADDR_W  default pixel and address/count widths
//   OP_*            datapath operation select codes
//   seq_state_t     frame sequencer FSM states
// ---------------------------------------------------------------------------
package pix_op_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned ADDR_W = 17;

    localparam logic [1:0] OP_BRIGHT_UP = 2'b00;
    localparam logic [1:0] OP_BRIGHT_DN = 2'b01;
    localparam logic [1:0] OP_THRESH    = 2'b10;
    localparam logic [1:0] OP_INVERT    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pix_skid_fifo.sv
// ---------------------------------------------------------------------------
// pix_skid_fifo
// Two-entry pixel FIFO absorbing RAM read data while the output sink stalls.
// A push into an empty FIFO is visible on o_head in the same cycle, so the
// read data can flow straight through to the datapath at full rate.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_push         write i_push_data this cycle
//   i_push_data    pixel to store
//   i_pop          consume o_head this cycle
//   o_count        stored entries (0..2, excludes a same-cycle push)
//   o_nonempty     o_head is valid (stored entry or same-cycle push)
//   o_head         oldest valid pixel, 0 when nothing is valid
// ---------------------------------------------------------------------------
module pix_skid_fifo
    import pix_op_pkg::*;
#(
    parameter int unsigned W = PIX_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic [1:0]   o_count,
    output logic         o_nonempty,
    output logic [W-1:0] o_head
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic w_bypass;
    logic w_store;
    logic w_take;

    // Push and pop of an empty FIFO pass the pixel straight through.
    assign w_bypass = i_push && i_pop && (r_count == 2'd0);
    assign w_store  = i_push && !w_bypass;
    assign w_take   = i_pop  && !w_bypass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_store) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_take) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_store, w_take})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count    = r_count;
    assign o_nonempty = (r_count != 2'd0) || i_push;
    assign o_head     = (r_count != 2'd0) ? r_mem[r_rd_ptr] :
                        (i_push ? i_push_data : '0);

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_store && !w_take && (r_count == 2'd2)));

    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(i_pop && !o_nonempty));

endmodule

// File: rtl/pixel_op_sequencer.sv
// ---------------------------------------------------------------------------
// pixel_op_sequencer
// Frame controller for the combinational pixel point-operation datapath.
// On an accepted start it latches the configuration, streams cfg_len pixels
// from the input RAM through the datapath into the output sink at one pixel
// per clock, and honours sink backpressure without loss or duplication.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start                         frame start request (IDLE only)
//   cfg_select/value/threshold    datapath configuration, latched at start
//   cfg_len                       pixels in the frame, latched at start
//   busy, done                    frame running / one-cycle completion pulse
//   rd_en, rd_addr, rd_data       input RAM port (1-cycle read latency)
//   dp_select/value/threshold     held datapath configuration
//   dp_inbyte, dp_outbyte         datapath pixel in / combinational result
//   wr_en, wr_addr, wr_data       output sink; write completes on wr_ready
//   wr_ready                      sink ready
// ---------------------------------------------------------------------------
module pixel_op_sequencer
    import pix_op_pkg::*;
#(
    parameter int unsigned ADDR_W = pix_op_pkg::ADDR_W,
    parameter int unsigned PIX_W  = pix_op_pkg::PIX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        cfg_select,
    input  logic [PIX_W-1:0]  cfg_value,
    input  logic [PIX_W-1:0]  cfg_threshold,
    input  logic [ADDR_W-1:0] cfg_len,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [1:0]        dp_select,
    output logic [PIX_W-1:0]  dp_value,
    output logic [PIX_W-1:0]  dp_threshold,
    output logic [PIX_W-1:0]  dp_inbyte,
    input  logic [PIX_W-1:0]  dp_outbyte,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    input  logic              wr_ready
);

    localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;

    logic [1:0]        r_sel;
    logic [PIX_W-1:0]  r_value;
    logic [PIX_W-1:0]  r_thr;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic              r_rd_inflight;
    logic              r_wr_en;
    logic [PIX_W-1:0]  r_wr_data;

    logic              w_accept;
    logic              w_pop;
    logic              w_wr_done;
    logic              w_last_wr;
    logic              w_rd_en;
    logic [1:0]        w_fifo_count;
    logic              w_fifo_nonempty;
    logic [PIX_W-1:0]  w_fifo_head;
    logic [2:0]        w_occ;
    logic [2:0]        w_room;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_wr_done = r_wr_en && wr_ready;
    assign w_last_wr = w_wr_done && (r_wr_cnt == (r_len - CNT_ONE));
    assign w_pop     = w_fifo_nonempty && (!r_wr_en || wr_ready);

    // Stored + in-flight - leaving must stay <= 1 so the read issued now
    // still has a FIFO slot when its data returns next cycle.
    assign w_occ   = {1'b0, w_fifo_count} + {2'b00, r_rd_inflight};
    assign w_room  = 3'd1 + {2'b00, w_pop};
    assign w_rd_en = (r_state == ST_RUN) && (r_rd_cnt != r_len) && (w_occ <= w_room);

    pix_skid_fifo #(
        .W (PIX_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_rd_inflight),
        .i_push_data (rd_data),
        .i_pop       (w_pop),
        .o_count     (w_fifo_count),
        .o_nonempty  (w_fifo_nonempty),
        .o_head      (w_fifo_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (cfg_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last_wr) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel         <= 2'b00;
            r_value       <= '0;
            r_thr         <= '0;
            r_len         <= '0;
            r_rd_cnt      <= '0;
            r_wr_cnt      <= '0;
            r_rd_inflight <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_data     <= '0;
        end else begin
            if (w_accept) begin
                r_sel    <= cfg_select;
                r_value  <= cfg_value;
                r_thr    <= cfg_threshold;
                r_len    <= cfg_len;
                r_rd_cnt <= '0;
                r_wr_cnt <= '0;
            end else begin
                if (w_rd_en) begin
                    r_rd_cnt <= r_rd_cnt + CNT_ONE;
                end
                if (w_wr_done) begin
                    r_wr_cnt <= r_wr_cnt + CNT_ONE;
                end
            end

            r_rd_inflight <= w_rd_en;

            if (w_pop) begin
                r_wr_data <= dp_outbyte;
                r_wr_en   <= 1'b1;
            end else if (w_wr_done) begin
                r_wr_en <= 1'b0;
            end
        end
    end

    assign rd_en        = w_rd_en;
    assign rd_addr      = r_rd_cnt;
    assign dp_select    = r_sel;
    assign dp_value     = r_value;
    assign dp_threshold = r_thr;
    assign dp_inbyte    = w_fifo_head;
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_cnt;
    assign wr_data      = r_wr_data;

endmodule

// File: tb/tb_pixel_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pixel_op_sequencer
// Directed frames against a behavioural datapath and input RAM. Expected
// writes are queued when a frame is started; a monitor pops and compares
// every completed write and checks that stalled outputs hold.
// ---------------------------------------------------------------------------
module tb_pixel_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  cfg_select;
    logic [7:0]  cfg_value;
    logic [7:0]  cfg_threshold;
    logic [16:0] cfg_len;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [16:0] rd_addr;
    logic [7:0]  rd_data = 8'h00;
    logic [1:0]  dp_select;
    logic [7:0]  dp_value;
    logic [7:0]  dp_threshold;
    logic [7:0]  dp_inbyte;
    logic [7:0]  dp_outbyte;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready = 1'b1;

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem [0:31];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         rmode    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pixel_op_sequencer #(
        .ADDR_W (17),
        .PIX_W  (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_select    (cfg_select),
        .cfg_value     (cfg_value),
        .cfg_threshold (cfg_threshold),
        .cfg_len       (cfg_len),
        .busy          (busy),
        .done          (done),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .dp_select     (dp_select),
        .dp_value      (dp_value),
        .dp_threshold  (dp_threshold),
        .dp_inbyte     (dp_inbyte),
        .dp_outbyte    (dp_outbyte),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready)
    );

    // Behavioural point-operation datapath.
    function automatic logic [7:0] f_op(input logic [1:0] s, input logic [7:0] v,
                                        input logic [7:0] t, input logic [7:0] x);
        logic [8:0] sum;
        case (s)
            2'b00: begin
                sum = {1'b0, x} + {1'b0, v};
                return sum[8] ? 8'hFF : sum[7:0];
            end
            2'b01:   return (x < v) ? 8'h00 : (x - v);
            2'b10:   return (x >= t) ? 8'hFF : 8'h00;
            default: return ~x;
        endcase
    endfunction

    assign dp_outbyte = f_op(dp_select, dp_value, dp_threshold, dp_inbyte);

    // Input RAM: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr[4:0]];
    end

    // Sink ready driver: always ready, or the 1,0,0,1 pattern.
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 1) begin
                wr_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
                phase++;
            end else begin
                wr_ready = 1'b1;
                phase    = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_exp(input int a, input logic [7:0] d);
        exp_t e;
        e.addr = a[16:0];
        e.data = d;
        sb.push_back(e);
    endtask

    // Monitor: score completed writes, check outputs hold while stalled.
    initial begin
        logic        prev_stall;
        logic [7:0]  prev_data;
        logic [16:0] prev_addr;
        exp_t        e;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        prev_addr  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_wr_en_held", {31'd0, wr_en}, 32'd1);
                    chk("stall_wr_data_held", {24'd0, wr_data}, {24'd0, prev_data});
                    chk("stall_wr_addr_held", {15'd0, wr_addr}, {15'd0, prev_addr});
                end
                if (wr_en && wr_ready) begin
                    chk("write_expected", {31'd0, sb.size() != 0}, 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("wr_addr", {15'd0, wr_addr}, {15'd0, e.addr});
                        chk("wr_data", {24'd0, wr_data}, {24'd0, e.data});
                    end
                end
                prev_stall = wr_en && !wr_ready;
                prev_data  = wr_data;
                prev_addr  = wr_addr;
            end
        end
    end

    int s_cyc;

    task automatic start_pulse(input logic [1:0] s, input logic [7:0] v,
                               input logic [7:0] t, input int l);
        @(posedge clk);
        #1;
        start         = 1'b1;
        cfg_select    = s;
        cfg_value     = v;
        cfg_threshold = t;
        cfg_len       = l[16:0];
        s_cyc         = cyc;
        @(posedge clk);
        #1;
        start         = 1'b0;
        cfg_select    = 2'b00;
        cfg_value     = 8'h00;
        cfg_threshold = 8'h00;
        cfg_len       = '0;
    endtask

    task automatic wait_done(input int max_cyc, output int done_cyc, output int first_rd,
                             output int first_wr, output logic any_busy, output logic busy_at_done);
        done_cyc     = -1;
        first_rd     = -1;
        first_wr     = -1;
        any_busy     = 1'b0;
        busy_at_done = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (rd_en && first_rd < 0) first_rd = cyc;
            if (wr_en && first_wr < 0) first_wr = cyc;
            if (busy) any_busy = 1'b1;
            if (done) begin
                done_cyc     = cyc;
                busy_at_done = busy;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   d, fr, fw, d1, found, bad;
        logic ab, bd;

        rst_n         = 1'b0;
        start         = 1'b0;
        cfg_select    = 2'b00;
        cfg_value     = 8'h00;
        cfg_threshold = 8'h00;
        cfg_len       = '0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_rd_addr", {15'd0, rd_addr}, 32'd0);
        chk("rst_wr_addr", {15'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("rst_dp_cfg", {14'd0, dp_select, dp_value, dp_threshold}, 32'd0);
        chk("rst_dp_inbyte", {24'd0, dp_inbyte}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Frame 1: brighten by 0x40 with saturation, full rate.
        mem[0] = 8'h10; mem[1] = 8'h80; mem[2] = 8'hF0; mem[3] = 8'h00;
        push_exp(0, 8'h50); push_exp(1, 8'hC0); push_exp(2, 8'hFF); push_exp(3, 8'h40);
        start_pulse(2'b00, 8'h40, 8'h00, 4);
        wait_done(50, d, fr, fw, ab, bd);
        chk("f1_first_rd_lat", fr - s_cyc, 32'd1);
        chk("f1_first_wr_lat", fw - s_cyc, 32'd3);
        chk("f1_done_lat", d - s_cyc, 32'd7);
        chk("f1_busy_seen", {31'd0, ab}, 32'd1);
        chk("f1_busy_at_done", {31'd0, bd}, 32'd0);
        chk("f1_sb_drained", sb.size(), 32'd0);
        @(negedge clk);
        chk("f1_done_one_cycle", {31'd0, done}, 32'd0);

        // Zero-length frame: straight to done, no traffic.
        start_pulse(2'b01, 8'h11, 8'h22, 0);
        wait_done(20, d, fr, fw, ab, bd);
        chk("f0_done_lat", d - s_cyc, 32'd1);
        chk("f0_no_rd", fr, 32'hFFFF_FFFF);
        chk("f0_no_wr", fw, 32'hFFFF_FFFF);
        chk("f0_never_busy", {31'd0, ab}, 32'd0);

        // 16 pixels, darken by 0x30, sink ready pattern 1,0,0,1.
        for (int k = 0; k < 16; k++) begin
            mem[k] = 8'(k * 17);
            push_exp(k, f_op(2'b01, 8'h30, 8'h00, 8'(k * 17)));
        end
        rmode = 1;
        start_pulse(2'b01, 8'h30, 8'h00, 16);
        wait_done(300, d, fr, fw, ab, bd);
        chk("f16_done_seen", {31'd0, d > s_cyc}, 32'd1);
        chk("f16_sb_drained", sb.size(), 32'd0);
        rmode = 0;

        // Threshold at 0x80; a second start during RUN must be ignored.
        mem[0] = 8'h7F; mem[1] = 8'h80; mem[2] = 8'h81;
        mem[3] = 8'h00; mem[4] = 8'hFF; mem[5] = 8'h10;
        push_exp(0, 8'h00); push_exp(1, 8'hFF); push_exp(2, 8'hFF);
        push_exp(3, 8'h00); push_exp(4, 8'hFF); push_exp(5, 8'h00);
        start_pulse(2'b10, 8'h00, 8'h80, 6);
        d1 = s_cyc;
        start_pulse(2'b11, 8'h99, 8'h01, 2);
        @(negedge clk);
        chk("ign_dp_select", {30'd0, dp_select}, 32'd2);
        chk("ign_dp_value", {24'd0, dp_value}, 32'd0);
        chk("ign_dp_threshold", {24'd0, dp_threshold}, 32'h80);
        wait_done(50, d, fr, fw, ab, bd);
        chk("ign_done_lat", d - d1, 32'd9);
        chk("ign_sb_drained", sb.size(), 32'd0);

        // Reset in the middle of a 10-pixel frame.
        for (int k = 0; k < 10; k++) begin
            mem[k] = 8'(8'h20 + k);
            push_exp(k, f_op(2'b00, 8'h05, 8'h00, 8'(8'h20 + k)));
        end
        start_pulse(2'b00, 8'h05, 8'h00, 10);
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wr_en && wr_ready && wr_addr == 17'd5) begin
                found = 1;
                break;
            end
        end
        chk("mid_reset_reached_px5", found, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("mid_rst_addrs", {15'd0, rd_addr | wr_addr}, 32'd0);
        chk("mid_rst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("mid_rst_dp_value", {24'd0, dp_value}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_en || wr_en || done || busy) bad++;
        end
        chk("post_rst_quiet", bad, 32'd0);

        // Back-to-back frames: invert, then threshold 0x82 started after done.
        mem[0] = 8'h81; mem[1] = 8'h82; mem[2] = 8'h7F;
        push_exp(0, 8'h7E); push_exp(1, 8'h7D); push_exp(2, 8'h80);
        start_pulse(2'b11, 8'h00, 8'h00, 3);
        wait_done(50, d, fr, fw, ab, bd);
        chk("b2b_f1_done_lat", d - s_cyc, 32'd6);
        push_exp(0, 8'h00); push_exp(1, 8'hFF); push_exp(2, 8'h00);
        start_pulse(2'b10, 8'h00, 8'h82, 3);
        chk("b2b_start_after_done", s_cyc - d, 32'd1);
        wait_done(50, d, fr, fw, ab, bd);
        chk("b2b_f2_done_lat", d - s_cyc, 32'd6);
        chk("b2b_f2_dp_cfg", {22'd0, dp_select, dp_threshold}, {22'd0, 2'b10, 8'h82});
        chk("b2b_sb_drained", sb.size(), 32'd0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
